// File: rtl/param_register_file.sv
// ============================================================================
// param_register_file
// ----------------------------------------------------------------------------
// Parametrised multi-port register file for the datapath. It replaces the
// fixed 16-bit / 32-entry register file. Decode drives the read addresses,
// writeback drives write port A (ALU result) and write port B (load result).
//
// Features
//   - Two write ports. Port A has priority over port B for the same address.
//   - NUM_RD combinational read ports with optional write-to-read bypass.
//   - Entry 0 is hardwired to zero.
//   - Full asynchronous reset.
//   - FSM-driven soft clear that walks the entries 1..NUM_REGS-1.
//
// Parameters
//   DATA_W    register width in bits
//   NUM_REGS  number of entries (>= 2, need not be a power of two)
//   ADDR_W    address width, 2**ADDR_W >= NUM_REGS
//   NUM_RD    number of read ports
//   BYPASS    1 = same-cycle write data is forwarded to the reads
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   wa_en/addr/data   write port A (highest priority)
//   wb_en/addr/data   write port B
//   rd_addr           flattened read addresses, port k = [k*ADDR_W +: ADDR_W]
//   rd_data           flattened read data,      port k = [k*DATA_W +: DATA_W]
//   clr_req           soft-clear request
//   clr_busy          soft clear in progress
//   clr_done          one-cycle pulse when the soft clear finishes
//   wr_drop           registered pulse: a requested write was discarded
//
// Optional build macro RF_PARITY_EN
//   Adds one even-parity bit per entry, plus these outputs:
//     rd_par_err      per-read-port parity mismatch
//     par_err_sticky  latched parity error; cleared by rst or at clr_done
// ============================================================================
module param_register_file #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 6,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wa_en,
    input  logic [ADDR_W-1:0]        wa_addr,
    input  logic [DATA_W-1:0]        wa_data,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     clr_req,
    output logic                     clr_busy,
    output logic                     clr_done,
`ifdef RF_PARITY_EN
    output logic [NUM_RD-1:0]        rd_par_err,
    output logic                     par_err_sticky,
`endif
    output logic                     wr_drop
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    // Entry count widened by one bit, so that the range check also works
    // when NUM_REGS == 2**ADDR_W.
    localparam logic [ADDR_W:0]   NUM_REGS_EXT = (ADDR_W + 1)'(NUM_REGS);
    localparam logic [ADDR_W-1:0] LAST_PTR     = ADDR_W'(NUM_REGS - 1);

    // Entry 0 is never stored. Its value is the constant zero.
    logic [DATA_W-1:0] mem [1:NUM_REGS-1];
`ifdef RF_PARITY_EN
    logic              par_mem [1:NUM_REGS-1];
`endif

    logic [0:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic              idle;

    logic wa_nz, wa_in, wb_nz, wb_in, same_addr;
    logic wa_ok, wb_ok, wa_drop, wb_drop;

    assign idle     = (state == ST_IDLE);
    assign clr_busy = (state == ST_CLEAR);

    // Write qualification.
    //   - A write is performed only in IDLE, to a nonzero, in-range address.
    //   - Port B also loses to port A when both ports target the same address.
    //   - A write to address 0 is silently ignored.
    //   - Every other rejected write is reported through wr_drop.
    assign wa_nz     = (wa_addr != '0);
    assign wb_nz     = (wb_addr != '0);
    assign wa_in     = ({1'b0, wa_addr} < NUM_REGS_EXT);
    assign wb_in     = ({1'b0, wb_addr} < NUM_REGS_EXT);
    assign same_addr = (wa_addr == wb_addr);

    assign wa_ok   = wa_en && idle && wa_nz && wa_in;
    assign wb_ok   = wb_en && idle && wb_nz && wb_in && !(wa_en && same_addr);
    assign wa_drop = wa_en && (!idle || (wa_nz && !wa_in));
    assign wb_drop = wb_en && (!idle || (wb_nz && (!wb_in || (wa_en && same_addr))));

    // Soft-clear sequencer.
    //   - ptr walks the entries 1..NUM_REGS-1, clearing one entry per edge.
    //   - The edge that clears the last entry returns the FSM to IDLE and
    //     raises clr_done for one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            ptr      <= ADDR_W'(1);
            clr_done <= 1'b0;
            wr_drop  <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            wr_drop  <= wa_drop | wb_drop;
            case (state)
                ST_IDLE: begin
                    if (clr_req) begin
                        state <= ST_CLEAR;
                        ptr   <= ADDR_W'(1);
                    end
                end
                ST_CLEAR: begin
                    ptr <= ptr + 1'b1;
                    if (ptr == LAST_PTR) begin
                        state    <= ST_IDLE;
                        clr_done <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Storage update.
    //   - During a clear, only the entry under ptr changes.
    //   - Otherwise port A is checked before port B. The two can only
    //     coincide on the same entry when wb_ok is already false.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                mem[i] <= '0;
`ifdef RF_PARITY_EN
                par_mem[i] <= 1'b0;
`endif
            end
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (!idle) begin
                    if (ptr == ADDR_W'(i)) begin
                        mem[i] <= '0;
`ifdef RF_PARITY_EN
                        par_mem[i] <= 1'b0;
`endif
                    end
                end else if (wa_ok && (wa_addr == ADDR_W'(i))) begin
                    mem[i] <= wa_data;
`ifdef RF_PARITY_EN
                    par_mem[i] <= ^wa_data;
`endif
                end else if (wb_ok && (wb_addr == ADDR_W'(i))) begin
                    mem[i] <= wb_data;
`ifdef RF_PARITY_EN
                    par_mem[i] <= ^wb_data;
`endif
                end
            end
        end
    end

    // Read ports.
    //   - The array lookup compares the address against each stored entry.
    //     Address 0 and out-of-range addresses therefore read zero.
    //   - Bypass needs wa_ok/wb_ok, which are only true in IDLE. Forwarding
    //     is therefore automatically off during a clear.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] arr_val;
        logic              hit_a;
        logic              hit_b;
`ifdef RF_PARITY_EN
        logic              arr_par;
        logic              arr_hit;
`endif

        assign addr = rd_addr[k*ADDR_W +: ADDR_W];

        always_comb begin
            arr_val = '0;
`ifdef RF_PARITY_EN
            arr_par = 1'b0;
            arr_hit = 1'b0;
`endif
            for (int i = 1; i < NUM_REGS; i++) begin
                if (addr == ADDR_W'(i)) begin
                    arr_val = mem[i];
`ifdef RF_PARITY_EN
                    arr_par = par_mem[i];
                    arr_hit = 1'b1;
`endif
                end
            end
        end

        assign hit_a = (BYPASS != 0) && wa_ok && (wa_addr == addr);
        assign hit_b = (BYPASS != 0) && wb_ok && (wb_addr == addr);

        assign rd_data[k*DATA_W +: DATA_W] = hit_a ? wa_data :
                                             hit_b ? wb_data : arr_val;

`ifdef RF_PARITY_EN
        // Forwarded data never came from storage, so it is not checked.
        assign rd_par_err[k] = arr_hit && !hit_a && !hit_b &&
                               ((^arr_val) != arr_par);
`endif
    end

`ifdef RF_PARITY_EN
    // A new error wins over the clear at clr_done, so that it is not lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_err_sticky <= 1'b0;
        end else if (|rd_par_err) begin
            par_err_sticky <= 1'b1;
        end else if (clr_done) begin
            par_err_sticky <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_param_register_file.sv
// ============================================================================
// tb_param_register_file
// ----------------------------------------------------------------------------
// Directed testbench for param_register_file.
//   - Two instances share every input: dut with BYPASS=1, dut_nb with BYPASS=0.
//   - Expected values are written out by hand at each step.
// ============================================================================
module tb_param_register_file;

    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 6;
    localparam int NUM_RD   = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     wa_en, wb_en, clr_req;
    logic [ADDR_W-1:0]        wa_addr, wb_addr;
    logic [DATA_W-1:0]        wa_data, wb_data;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data, rd_data_nb;
    logic                     clr_busy, clr_done, wr_drop;
    logic                     clr_busy_nb, clr_done_nb, wr_drop_nb;
`ifdef RF_PARITY_EN
    logic [NUM_RD-1:0]        rd_par_err, rd_par_err_nb;
    logic                     par_err_sticky, par_err_sticky_nb;
`endif

    int checks = 0;
    int errors = 0;
    int busy_cnt, done_cnt, drop_cnt;

    always #5 clk = ~clk;

    param_register_file #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W),
        .NUM_RD(NUM_RD), .BYPASS(1)
    ) dut (
        .clk(clk), .rst(rst),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done),
`ifdef RF_PARITY_EN
        .rd_par_err(rd_par_err), .par_err_sticky(par_err_sticky),
`endif
        .wr_drop(wr_drop)
    );

    param_register_file #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W),
        .NUM_RD(NUM_RD), .BYPASS(0)
    ) dut_nb (
        .clk(clk), .rst(rst),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .rd_addr(rd_addr), .rd_data(rd_data_nb),
        .clr_req(clr_req), .clr_busy(clr_busy_nb), .clr_done(clr_done_nb),
`ifdef RF_PARITY_EN
        .rd_par_err(rd_par_err_nb), .par_err_sticky(par_err_sticky_nb),
`endif
        .wr_drop(wr_drop_nb)
    );

    // Compares one observed value with its expected value and counts the result.
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives every DUT input in a single call.
    task automatic applyStimulus(input logic a_en, input logic [ADDR_W-1:0] a_addr,
                                 input logic [DATA_W-1:0] a_data,
                                 input logic b_en, input logic [ADDR_W-1:0] b_addr,
                                 input logic [DATA_W-1:0] b_data,
                                 input logic [ADDR_W-1:0] r0, input logic [ADDR_W-1:0] r1,
                                 input logic creq);
        wa_en   = a_en;  wa_addr = a_addr; wa_data = a_data;
        wb_en   = b_en;  wb_addr = b_addr; wb_data = b_data;
        rd_addr = {r1, r0};
        clr_req = creq;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] port(input logic [NUM_RD*DATA_W-1:0] bus,
                                               input int k);
        return bus[k*DATA_W +: DATA_W];
    endfunction

    // Fill pattern: nonzero for every entry 1..31, and distinct per entry.
    function automatic logic [DATA_W-1:0] fill(input int i);
        logic [7:0] b;
        b = i[7:0];
        return {b, ~b};
    endfunction

    initial begin
        // Reset state
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_clr_busy", 32'(clr_busy), 0);
        checkOutput("reset_clr_done", 32'(clr_done), 0);
        checkOutput("reset_wr_drop", 32'(wr_drop), 0);
        rst = 1'b0;

        // Every in-range and out-of-range address reads zero after reset
        for (int a = 0; a < 32; a++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 6'(a), 6'(63 - a), 0);
            #1;
            checkOutput("reset_read_p0", 32'(port(rd_data, 0)), 0);
            checkOutput("reset_read_p1", 32'(port(rd_data, 1)), 0);
        end

        // A writes addr 5 = BEEF; forwarded only by the bypass instance
        tick;
        applyStimulus(1, 5, 16'hBEEF, 0, 0, 0, 5, 0, 0);
        #1;
        checkOutput("byp_a5_p0", 32'(port(rd_data, 0)), 32'hBEEF);
        checkOutput("nobyp_a5_p0", 32'(port(rd_data_nb, 0)), 0);
        checkOutput("byp_a5_p1_addr0", 32'(port(rd_data, 1)), 0);
        tick;
        applyStimulus(0, 0, 0, 0, 0, 0, 5, 0, 0);
        #1;
        checkOutput("arr_a5_p0", 32'(port(rd_data, 0)), 32'hBEEF);
        checkOutput("arr_a5_p1_addr0", 32'(port(rd_data, 1)), 0);
        checkOutput("arr_a5_nb", 32'(port(rd_data_nb, 0)), 32'hBEEF);
        checkOutput("a5_wr_drop", 32'(wr_drop), 0);

        // A write to address 0 is ignored and raises no drop
        applyStimulus(1, 0, 16'h1234, 0, 0, 0, 0, 5, 0);
        #1;
        checkOutput("addr0_byp", 32'(port(rd_data, 0)), 0);
        tick;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 5, 0);
        #1;
        checkOutput("addr0_read", 32'(port(rd_data, 0)), 0);
        checkOutput("addr0_wr_drop", 32'(wr_drop), 0);

        // A and B both write addr 7; A wins and B is dropped
        applyStimulus(1, 7, 16'h1111, 1, 7, 16'h2222, 7, 7, 0);
        #1;
        checkOutput("collide_byp", 32'(port(rd_data, 0)), 32'h1111);
        checkOutput("collide_nobyp", 32'(port(rd_data_nb, 1)), 0);
        tick;
        applyStimulus(0, 0, 0, 0, 0, 0, 7, 7, 0);
        #1;
        checkOutput("collide_wr_drop", 32'(wr_drop), 1);
        checkOutput("collide_wr_drop_nb", 32'(wr_drop_nb), 1);
        checkOutput("collide_arr", 32'(port(rd_data, 0)), 32'h1111);
        checkOutput("collide_arr_nb", 32'(port(rd_data_nb, 1)), 32'h1111);
        tick;
        checkOutput("collide_wr_drop_end", 32'(wr_drop), 0);

        // B alone writes addr 3, then A overwrites it while port 1 reads it
        applyStimulus(0, 0, 0, 1, 3, 16'h0303, 0, 3, 0);
        tick;
        applyStimulus(1, 3, 16'hA5A5, 0, 0, 0, 0, 3, 0);
        #1;
        checkOutput("b_write_wr_drop", 32'(wr_drop), 0);
        checkOutput("byp_a3_p1", 32'(port(rd_data, 1)), 32'hA5A5);
        checkOutput("nobyp_a3_p1", 32'(port(rd_data_nb, 1)), 32'h0303);
        tick;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 3, 0);
        #1;
        checkOutput("arr_a3_p1", 32'(port(rd_data, 1)), 32'hA5A5);
        checkOutput("arr_a3_nb", 32'(port(rd_data_nb, 1)), 32'hA5A5);

        // An out-of-range write is dropped; the last entry (31) is writable
        applyStimulus(1, 31, 16'h3131, 1, 40, 16'hFFFF, 40, 31, 0);
        #1;
        checkOutput("oor_read", 32'(port(rd_data, 0)), 0);
        checkOutput("byp_a31", 32'(port(rd_data, 1)), 32'h3131);
        tick;
        applyStimulus(0, 0, 0, 0, 0, 0, 40, 31, 0);
        #1;
        checkOutput("oor_wr_drop", 32'(wr_drop), 1);
        checkOutput("arr_a31", 32'(port(rd_data_nb, 1)), 32'h3131);
        checkOutput("oor_read_after", 32'(port(rd_data, 0)), 0);

        // Fill entries 1..31
        for (int i = 1; i < NUM_REGS; i++) begin
            applyStimulus(1, 6'(i), fill(i), 0, 0, 0, 0, 0, 0);
            tick;
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 9, 30, 0);
        #1;
        checkOutput("fill_wr_drop", 32'(wr_drop), 0);
        checkOutput("fill_a9", 32'(port(rd_data, 0)), 32'(fill(9)));
        checkOutput("fill_a30", 32'(port(rd_data, 1)), 32'(fill(30)));

        // Soft clear, with a write attempted while the clear is running
        applyStimulus(0, 0, 0, 0, 0, 0, 9, 30, 1);
        tick;
        busy_cnt = 0;
        done_cnt = 0;
        drop_cnt = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (clr_busy) busy_cnt++;
            if (clr_done) done_cnt++;
            if (wr_drop) drop_cnt++;
            if (cyc == 2) begin
                applyStimulus(1, 9, 16'hDEAD, 0, 0, 0, 9, 30, 0);
                #1;
                checkOutput("clear_no_byp", 32'(port(rd_data, 0)), 32'(fill(9)));
            end else if (cyc == 5) begin
                applyStimulus(0, 0, 0, 0, 0, 0, 1, 30, 0);
                #1;
                checkOutput("clear_a1_zero", 32'(port(rd_data, 0)), 0);
                checkOutput("clear_a30_kept", 32'(port(rd_data, 1)), 32'(fill(30)));
            end else begin
                applyStimulus(0, 0, 0, 0, 0, 0, 1, 30, 0);
            end
            tick;
        end
        checkOutput("clear_busy_cycles", 32'(busy_cnt), 31);
        checkOutput("clear_done_pulses", 32'(done_cnt), 1);
        checkOutput("clear_drop_pulses", 32'(drop_cnt), 1);
        checkOutput("clear_done_nb", 32'(clr_done_nb), 0);
        for (int a = 1; a < NUM_REGS; a++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 6'(a), 6'(a), 0);
            #1;
            checkOutput("cleared_p0", 32'(port(rd_data, 0)), 0);
            checkOutput("cleared_nb_p1", 32'(port(rd_data_nb, 1)), 0);
        end

        // Reset in the middle of a soft clear
        tick;
        applyStimulus(1, 4, 16'h4444, 1, 31, 16'h3131, 4, 31, 0);
        tick;
        applyStimulus(0, 0, 0, 0, 0, 0, 4, 31, 1);
        tick;
        applyStimulus(0, 0, 0, 0, 0, 0, 4, 31, 0);
        repeat (10) tick;
        checkOutput("midclr_busy_before", 32'(clr_busy), 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midclr_busy", 32'(clr_busy), 0);
        checkOutput("midclr_busy_nb", 32'(clr_busy_nb), 0);
        checkOutput("midclr_done", 32'(clr_done), 0);
        checkOutput("midclr_a4", 32'(port(rd_data, 0)), 0);
        checkOutput("midclr_a31", 32'(port(rd_data, 1)), 0);
        #1;
        rst = 1'b0;
        tick;
        checkOutput("midclr_idle_after", 32'(clr_busy), 0);

`ifdef RF_PARITY_EN
        // Corrupt one stored bit of entry 4 and check the parity error flags
        applyStimulus(1, 4, 16'h0007, 0, 0, 0, 5, 4, 0);
        tick;
        applyStimulus(0, 0, 0, 0, 0, 0, 5, 4, 0);
        #1;
        checkOutput("par_clean", 32'(rd_par_err), 0);
        dut.mem[4] = dut.mem[4] ^ 16'h0001;
        #1;
        checkOutput("par_err_port1", 32'(rd_par_err), 32'h2);
        tick;
        checkOutput("par_sticky", 32'(par_err_sticky), 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Stops the run if the main sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/param_register_file.md
Name: param_register_file

Overview:
- Parametrised multi-port register file; successor to the fixed 16-bit/32-entry register file in the datapath.
- Adds two prioritised write ports, N read ports, write-to-read bypass, full async reset and an FSM-driven soft-clear sequencer.
- Sits between decode (read addresses) and writeback (ALU result on port A, load result on port B).

Parameters:
- DATA_W, 16, register width in bits
- NUM_REGS, 32, number of entries (≥2, need not be a power of 2)
- ADDR_W, 6, address width; must satisfy 2**ADDR_W ≥ NUM_REGS
- NUM_RD, 2, number of read ports
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see array only

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- wa_en  in  1  write port A enable (highest priority)
- wa_addr  in  ADDR_W  write port A address
- wa_data  in  DATA_W  write port A data
- wb_en  in  1  write port B enable
- wb_addr  in  ADDR_W  write port B address
- wb_data  in  DATA_W  write port B data
- rd_addr  in  NUM_RD*ADDR_W  flattened read addresses; port k = bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  flattened read data; port k = bits [k*DATA_W +: DATA_W]
- clr_req  in  1  soft-clear request
- clr_busy  out  1  soft clear in progress
- clr_done  out  1  one-cycle pulse when soft clear finishes
- wr_drop  out  1  registered pulse: a requested write was discarded

Behaviour:
- Reset (async): all entries 0..NUM_REGS-1 = 0; FSM = IDLE; ptr = 1; clr_busy = 0; clr_done = 0; wr_drop = 0.
- Entry 0 is hardwired zero:
  - reads of address 0 return 0;
  - writes to address 0 are ignored and do not assert wr_drop.
- Addresses ≥ NUM_REGS:
  - reads return 0;
  - writes are ignored and assert wr_drop the next cycle.
- Writes take effect on posedge clk.
  - If wa_en and wb_en target the same address, A wins; B is discarded and wr_drop pulses.
- Reads are combinational, zero latency.
  - With BYPASS=1, a read matching a same-cycle valid write returns that write data (A before B).
  - A write is valid here only if its address is nonzero, in range, FSM is IDLE, and for B it is not overridden by A.
  - With BYPASS=0, reads return the pre-edge array value.
- FSM states: IDLE, CLEAR.
- IDLE → CLEAR: on a clock edge with clr_req=1.
  - ptr ← 1, clr_busy ← 1.
  - Writes presented on that same edge are still performed.
- In CLEAR, on each edge:
  - array[ptr] ← 0, ptr ← ptr+1.
  - When ptr == NUM_REGS-1: state ← IDLE, clr_busy ← 0, clr_done ← 1 for exactly one cycle.
- clr_busy is high for exactly NUM_REGS-1 cycles.
- In CLEAR:
  - all writes are discarded, each asserting wr_drop;
  - clr_req is ignored;
  - bypass is disabled;
  - reads return current array contents (already-cleared entries read 0).
- wr_drop: registered, high the cycle after any discarded write, otherwise 0.
- Reset mid-clear: immediate return to IDLE with all outputs at reset values.

Optional Feature:
- Macro: RF_PARITY_EN.
- Defined:
  - each entry stores an extra even-parity bit, computed from the write data on write;
  - the soft clear and reset write parity 0;
  - extra output rd_par_err (NUM_RD bits) flags a combinational parity mismatch per read port;
  - bypassed reads and address-0 reads report 0;
  - extra output par_err_sticky (1 bit) is set on the edge after any rd_par_err bit is high, and cleared by rst or at clr_done.
- Undefined: no parity storage, no parity ports.

Test Plan:
- Reset, then read all addresses → every rd_data = 0, including address 31; clr_busy=0, wr_drop=0.
- Write A addr 5 = 0xBEEF, then read addr 5 on port 0 and addr 0 on port 1 → 0xBEEF and 0x0000. Write addr 0 = 0x1234 → still reads 0, wr_drop stays 0.
- Same cycle: A and B both write addr 7 (0x1111 / 0x2222), read addr 7 → bypass returns 0x1111; after the edge the array holds 0x1111 and wr_drop pulses once.
- BYPASS=1: A writes addr 3 = 0xA5A5 while port 1 reads addr 3 → 0xA5A5 in the same cycle. BYPASS=0: same stimulus reads the old value.
- Fill entries 1..31 with nonzero data, pulse clr_req, write addr 9 during CLEAR →
  - clr_busy high for 31 cycles, clr_done pulses once;
  - wr_drop pulses once;
  - all entries read 0 afterwards.
- Assert rst at cycle 10 of a soft clear → clr_busy=0 immediately, all entries 0. With RF_PARITY_EN, force-flip one stored bit of addr 4 → rd_par_err bit for that port = 1; par_err_sticky = 1 next cycle.
